// File: rtl/flt_seq_pkg.sv
// Shared types and constants for the float16 job sequencer.
// States, operand layout, default byte addresses and the operand load order.
package flt_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRST  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        RD    = 3'd5,
        OUT   = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic       sign;
        logic [4:0] exponent;
        logic [9:0] mant;
    } flt16_t;

    localparam int DEF_IN_BASE  = 8;
    localparam int DEF_OUT_BASE = 12;

    // Entry k sits at bits [2k+1:2k] as {operand_is_b, high_byte}.
    // Load order: a.lo, a.hi, b.lo, b.hi (little-endian, a first).
    localparam logic [7:0] BYTE_ORDER = {2'b11, 2'b10, 2'b01, 2'b00};

    function automatic logic [7:0] load_byte(input flt16_t a, input flt16_t b,
                                             input logic [1:0] k);
        logic [1:0]  sel;
        logic [15:0] word;
        sel = BYTE_ORDER[{k, 1'b0} +: 2];
        if (sel[1]) begin
            word = b;
        end else begin
            word = a;
        end
        if (sel[0]) begin
            load_byte = word[15:8];
        end else begin
            load_byte = word[7:0];
        end
    endfunction

endpackage

// File: rtl/flt_seq_cyc_counter.sv
// Saturating cycle counter with synchronous clear, count enable and an
// optional compare against LIMIT (hit is forced low when lim_en is 0).
module flt_seq_cyc_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 25000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         lim_en,
    output logic [W-1:0] count,
    output logic         hit
);

    logic [W-1:0] count_r;

    // Count up while enabled, sticking at all-ones; clear wins over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign hit   = lim_en && (count_r == W'(LIMIT));

endmodule

// File: rtl/flt_job_sequencer.sv
// Front end for the float16 add program: accepts an operand pair, resets the
// processor, loads the operands into data memory, starts it, waits for ack,
// reads the result back and presents it with the elapsed cycle count.
// Optional watchdog: define FLT_SEQ_WATCHDOG_EN to abandon WAIT after
// WD_LIMIT cycles and flag the result with res_timeout. Without the macro
// WAIT is unbounded and res_timeout stays 0.
module flt_job_sequencer
    import flt_seq_pkg::*;
#(
    parameter int IN_BASE  = DEF_IN_BASE,
    parameter int OUT_BASE = DEF_OUT_BASE,
    parameter int CYC_W    = 16,
    parameter int WD_LIMIT = 25000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [CYC_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic             proc_reset,
    output logic             proc_start,
    input  logic             proc_ack,
    output logic             dm_we,
    output logic [7:0]       dm_addr,
    output logic [7:0]       dm_wdata,
    input  logic [7:0]       dm_rdata
);

`ifdef FLT_SEQ_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    seq_state_t       state_r, state_s;
    logic [1:0]       k_r, k_s;
    flt16_t           a_r, a_s, b_r, b_s;
    logic             ready_r, ready_s, valid_r, valid_s;
    logic             prst_r, prst_s, start_r, start_s;
    logic             we_r, we_s, timeout_r, timeout_s;
    logic [7:0]       addr_r, addr_s, wdata_r, wdata_s;
    logic [15:0]      data_r, data_s;
    logic [CYC_W-1:0] cyc_r, cyc_s, cnt_s;
    logic             cnt_clr_s, cnt_en_s, wd_hit_s;

    flt_seq_cyc_counter #(.W(CYC_W), .LIMIT(WD_LIMIT)) u_cyc (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .lim_en (WD_EN),
        .count  (cnt_s),
        .hit    (wd_hit_s)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        a_s       = a_r;
        b_s       = b_r;
        ready_s   = 1'b0;
        valid_s   = 1'b0;
        prst_s    = 1'b0;
        start_s   = 1'b0;
        we_s      = 1'b0;
        addr_s    = 8'h00;
        wdata_s   = 8'h00;
        data_s    = data_r;
        cyc_s     = cyc_r;
        timeout_s = timeout_r;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (op_valid && ready_r) begin
                    a_s     = op_a;
                    b_s     = op_b;
                    prst_s  = 1'b1;
                    state_s = PRST;
                end else begin
                    ready_s = 1'b1;
                end
            end
            PRST: begin
                k_s     = 2'd0;
                we_s    = 1'b1;
                addr_s  = 8'(IN_BASE);
                wdata_s = load_byte(a_r, b_r, 2'd0);
                state_s = LOAD;
            end
            LOAD: begin
                if (k_r == 2'd3) begin
                    start_s = 1'b1;
                    state_s = START;
                end else begin
                    k_s     = k_r + 2'd1;
                    we_s    = 1'b1;
                    addr_s  = 8'(IN_BASE) + {6'd0, k_s};
                    wdata_s = load_byte(a_r, b_r, k_s);
                end
            end
            START: begin
                cnt_clr_s = 1'b1;
                state_s   = WAIT;
            end
            WAIT: begin
                // cnt_s is 0 only in the first WAIT cycle, where a lagging
                // ack from the previous job may still be visible.
                if (proc_ack && (cnt_s != {CYC_W{1'b0}})) begin
                    cnt_en_s  = 1'b1;
                    timeout_s = 1'b0;
                    k_s       = 2'd0;
                    addr_s    = 8'(OUT_BASE);
                    state_s   = RD;
                end else if (wd_hit_s) begin
                    timeout_s = 1'b1;
                    k_s       = 2'd0;
                    addr_s    = 8'(OUT_BASE);
                    state_s   = RD;
                end else begin
                    cnt_en_s  = 1'b1;
                end
            end
            RD: begin
                case (k_r)
                    2'd0: begin
                        addr_s = 8'(OUT_BASE) + 8'd1;
                        k_s    = 2'd1;
                    end
                    2'd1: begin
                        data_s[7:0] = dm_rdata;
                        k_s         = 2'd2;
                    end
                    2'd2: begin
                        data_s[15:8] = dm_rdata;
                        cyc_s        = cnt_s;
                        valid_s      = 1'b1;
                        state_s      = OUT;
                    end
                    default: begin
                        ready_s = 1'b1;
                        state_s = IDLE;
                    end
                endcase
            end
            OUT: begin
                if (res_ready) begin
                    ready_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                ready_s = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset holds the processor in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            k_r       <= 2'd0;
            a_r       <= 16'h0000;
            b_r       <= 16'h0000;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            prst_r    <= 1'b1;
            start_r   <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 8'h00;
            wdata_r   <= 8'h00;
            data_r    <= 16'h0000;
            cyc_r     <= {CYC_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            a_r       <= a_s;
            b_r       <= b_s;
            ready_r   <= ready_s;
            valid_r   <= valid_s;
            prst_r    <= prst_s;
            start_r   <= start_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            data_r    <= data_s;
            cyc_r     <= cyc_s;
            timeout_r <= timeout_s;
        end
    end

    assign op_ready    = ready_r;
    assign res_valid   = valid_r;
    assign res_data    = data_r;
    assign res_cycles  = cyc_r;
    assign res_timeout = timeout_r;
    assign proc_reset  = prst_r;
    assign proc_start  = start_r;
    assign dm_we       = we_r;
    assign dm_addr     = addr_r;
    assign dm_wdata    = wdata_r;

endmodule

// File: tb/tb_flt_job_sequencer.sv
// Scoreboard bench for flt_job_sequencer: a processor/data-memory model
// answers the DUT, stimulus pushes expected writes and results into queues,
// and a negedge monitor pops and compares them.
module tb_flt_job_sequencer;

    localparam int NV = 16;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] c;
        logic        t;
    } res_exp_t;

    logic        clk = 1'b0;
    logic        reset, op_valid, res_ready;
    logic [15:0] op_a, op_b;
    logic        proc_ack = 1'b0;
    logic [7:0]  dm_rdata = 8'h00;
    logic        op_ready, res_valid, res_timeout, proc_reset, proc_start, dm_we;
    logic [15:0] res_data, res_cycles;
    logic [7:0]  dm_addr, dm_wdata;

    int checks = 0;
    int errors = 0;
    int n_results = 0;
    int n_sent = 0;
    int job_wr = 0;
    int job_st = 0;
    bit stale_mode = 1'b0;
    logic [15:0] last_res = 16'h0000;

    logic [15:0] va [NV];
    logic [15:0] vb [NV];
    logic [15:0] vr [NV];
    int          vd [NV];

    res_exp_t    eq [$];
    logic [15:0] wq [$];

    logic [7:0]  mem [256];
    logic [7:0]  prev_addr = 8'h00;
    bit          busy = 1'b0;
    int          w = 0;
    int          cur_d = 0;
    logic [15:0] cur_r = 16'h0000;

    always #5 clk = ~clk;

    flt_job_sequencer #(
        .IN_BASE(8), .OUT_BASE(12), .CYC_W(16), .WD_LIMIT(100)
    ) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cycles(res_cycles), .res_timeout(res_timeout),
        .proc_reset(proc_reset), .proc_start(proc_start), .proc_ack(proc_ack),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic int find_vec(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < NV; i++) begin
            if (va[i] == a && vb[i] == b) return i;
        end
        return -1;
    endfunction

    // Processor + data memory model: registered reads, ack after vd cycles,
    // ack held until the next proc_reset (stale_mode keeps it longer).
    always begin
        int idx;
        @(posedge clk);
        #1;
        dm_rdata  = mem[prev_addr];
        prev_addr = dm_addr;
        if (dm_we) mem[dm_addr] = dm_wdata;
        if (proc_reset) begin
            busy = 1'b0;
            if (!stale_mode) proc_ack = 1'b0;
        end
        if (busy) begin
            w++;
            if (stale_mode && w == 2) proc_ack = 1'b0;
            if (w == cur_d) begin
                mem[12]  = cur_r[7:0];
                mem[13]  = cur_r[15:8];
                proc_ack = 1'b1;
                busy     = 1'b0;
            end
        end
        if (proc_start) begin
            idx = find_vec({mem[9], mem[8]}, {mem[11], mem[10]});
            if (idx < 0) begin
                cur_r = 16'hDEAD;
                cur_d = 5;
            end else begin
                cur_r = vr[idx];
                cur_d = vd[idx];
            end
            busy = 1'b1;
            w    = 0;
        end
    end

    // Monitor: checks every data-memory write and every accepted result.
    always @(negedge clk) begin
        res_exp_t e;
        logic [15:0] ew;
        if (proc_reset) begin
            job_wr = 0;
            job_st = 0;
        end
        if (proc_start) job_st++;
        if (dm_we) begin
            job_wr++;
            if (wq.size() == 0) begin
                chk("unexpected_dm_write", {16'h0000, dm_addr, dm_wdata}, 32'hFFFFFFFF);
            end else begin
                ew = wq.pop_front();
                chk("dm_addr", {24'h0, dm_addr}, {24'h0, ew[15:8]});
                chk("dm_wdata", {24'h0, dm_wdata}, {24'h0, ew[7:0]});
            end
        end
        if (res_valid && res_ready) begin
            if (eq.size() == 0) begin
                chk("unexpected_result", {16'h0000, res_data}, 32'hFFFFFFFF);
            end else begin
                e = eq.pop_front();
                chk("res_data", {16'h0, res_data}, {16'h0, e.d});
                chk("res_cycles", {16'h0, res_cycles}, {16'h0, e.c});
                chk("res_timeout", {31'h0, res_timeout}, {31'h0, e.t});
                chk("job_writes", job_wr, 32'd4);
                chk("job_starts", job_st, 32'd1);
            end
            n_results++;
        end
    end

    task automatic send(input int idx, input bit expect_res, input bit wd);
        int t;
        res_exp_t e;
        t = 0;
        while (op_ready !== 1'b1 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("op_ready_before_send", {31'h0, op_ready}, 32'd1);
        wq.push_back({8'd8,  va[idx][7:0]});
        wq.push_back({8'd9,  va[idx][15:8]});
        wq.push_back({8'd10, vb[idx][7:0]});
        wq.push_back({8'd11, vb[idx][15:8]});
        if (expect_res) begin
            if (wd) begin
                e.d = last_res;
                e.c = 16'd100;
                e.t = 1'b1;
            end else begin
                e.d = vr[idx];
                e.c = vd[idx][15:0];
                e.t = 1'b0;
                last_res = vr[idx];
            end
            eq.push_back(e);
            n_sent++;
        end
        op_valid = 1'b1;
        op_a = va[idx];
        op_b = vb[idx];
        @(posedge clk);
        #1;
        // Keep offering changing garbage while busy; it must be ignored.
        op_a = 16'hFFFF;
        op_b = 16'h1234;
        @(posedge clk);
        #1;
        op_a = 16'h0F0F;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (n_results != n_sent && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("results_received", n_results, n_sent);
    endtask

    task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input int d);
        va[i] = a;
        vb[i] = b;
        vr[i] = r;
        vd[i] = d;
    endtask

    initial begin
        int t;
        set_vec(0,  16'h1A04, 16'h1A04, 16'h1E04, 40);
        set_vec(1,  16'h3C00, 16'h3C00, 16'h4000, 2);
        set_vec(2,  16'h3C00, 16'h4000, 16'h4200, 3);
        set_vec(3,  16'h4000, 16'h4000, 16'h4400, 7);
        set_vec(4,  16'h3800, 16'h3800, 16'h3C00, 12);
        set_vec(5,  16'h3C00, 16'hBC00, 16'h0000, 4);
        set_vec(6,  16'h4200, 16'h3C00, 16'h4400, 9);
        set_vec(7,  16'h4400, 16'h4000, 16'h4600, 5);
        set_vec(8,  16'h3C00, 16'h3800, 16'h3E00, 15);
        set_vec(9,  16'h4500, 16'h3C00, 16'h4600, 6);
        set_vec(10, 16'h4800, 16'h4800, 16'h4C00, 3);
        set_vec(11, 16'hC000, 16'hC000, 16'hC400, 8);
        set_vec(12, 16'h4000, 16'hBC00, 16'h3C00, 11);
        set_vec(13, 16'h0000, 16'h3C00, 16'h3C00, 6);
        set_vec(14, 16'h4400, 16'h4400, 16'h4800, 60);
        set_vec(15, 16'h5555, 16'hAAAA, 16'h0000, 0);

        reset = 1'b1;
        op_valid = 1'b0;
        op_a = 16'h0000;
        op_b = 16'h0000;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", {31'h0, op_ready}, 32'd1);
        chk("rst_res_valid", {31'h0, res_valid}, 32'd0);
        chk("rst_res_data", {16'h0, res_data}, 32'd0);
        chk("rst_res_cycles", {16'h0, res_cycles}, 32'd0);
        chk("rst_res_timeout", {31'h0, res_timeout}, 32'd0);
        chk("rst_proc_reset", {31'h0, proc_reset}, 32'd1);
        chk("rst_proc_start", {31'h0, proc_start}, 32'd0);
        chk("rst_dm_we", {31'h0, dm_we}, 32'd0);
        chk("rst_dm_addr", {24'h0, dm_addr}, 32'd0);
        chk("rst_dm_wdata", {24'h0, dm_wdata}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("proc_reset_release", {31'h0, proc_reset}, 32'd0);

        // Single job, ack 40 cycles after start.
        send(0, 1'b1, 1'b0);
        wait_done();

        // Backpressure: result held for 10 cycles.
        res_ready = 1'b0;
        send(2, 1'b1, 1'b0);
        t = 0;
        while (res_valid !== 1'b1 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", {31'h0, res_valid}, 32'd1);
            chk("bp_res_data", {16'h0, res_data}, {16'h0, vr[2]});
            chk("bp_op_ready", {31'h0, op_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_op_ready_after", {31'h0, op_ready}, 32'd1);
        chk("bp_res_valid_after", {31'h0, res_valid}, 32'd0);
        wait_done();

        // Stale ack from the previous job stays high into the first WAIT cycle.
        stale_mode = 1'b1;
        send(13, 1'b1, 1'b0);
        wait_done();
        stale_mode = 1'b0;

        // Reset while waiting for ack: result discarded, no further writes.
        send(14, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_op_ready", {31'h0, op_ready}, 32'd1);
        chk("abort_res_valid", {31'h0, res_valid}, 32'd0);
        chk("abort_proc_reset", {31'h0, proc_reset}, 32'd1);
        chk("abort_dm_we", {31'h0, dm_we}, 32'd0);
        reset = 1'b0;
        chk("abort_writes_drained", wq.size(), 32'd0);
        repeat (80) @(posedge clk);
        #1;
        chk("abort_no_result", n_results, n_sent);

        // Back-to-back stream of 12 jobs.
        for (int i = 1; i <= 12; i++) begin
            send(i, 1'b1, 1'b0);
        end
        wait_done();

`ifdef FLT_SEQ_WATCHDOG_EN
        // Never-acked job times out; the next job clears the flag.
        send(15, 1'b1, 1'b1);
        wait_done();
        send(1, 1'b1, 1'b0);
        wait_done();
`endif

        chk("scoreboard_empty", eq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
